// File: rtl/wdata_burst_issuer.sv
`default_nettype none
// ============================================================================
// Module   : wdata_burst_issuer
// Purpose  : Pops one burst entry per WRITE command and serializes it onto DQ
//            exactly WL cycles after the command.
// Revision : 1.0 - initial release
// ============================================================================
module wdata_burst_issuer #(
    parameter  int DATA_WIDTH = 128,
    parameter  int BURST_LEN  = 8,
    parameter  int WL         = 5,
    localparam int DQ_WIDTH   = DATA_WIDTH / BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_cmd_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic [DQ_WIDTH-1:0]   dq_out,
    output logic                  dq_oe,
    output logic                  busy,
    output logic                  underflow_err,
    output logic                  spacing_err
);

    localparam int c_BEAT_W = $clog2(BURST_LEN);
    localparam int c_SPC_W  = $clog2(BURST_LEN + 1);
    localparam int c_PIPE_W = WL - 1;
    localparam logic [c_SPC_W-1:0]  c_SPC_SAT   = c_SPC_W'(BURST_LEN);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_SPC_W-1:0]    r_spc_cnt;
    logic [c_PIPE_W-1:0]   r_pipe;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [DATA_WIDTH-1:0] r_shift;

    state_t                w_state_next;
    logic [c_SPC_W-1:0]    w_spc_next;
    logic [c_PIPE_W-1:0]   w_pipe_next;
    logic [c_BEAT_W-1:0]   w_beat_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DQ_WIDTH-1:0]   w_dq_next;
    logic                  w_oe_next;
    logic                  w_busy_next;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_tap;

    // Counter holds cycles elapsed since the last accepted command, saturated.
    assign w_accept    = wr_cmd_valid && (r_spc_cnt >= c_SPC_SAT);
    assign w_drop      = wr_cmd_valid && !w_accept;
    assign w_spc_next  = w_accept ? c_SPC_W'(1) :
                         (r_spc_cnt < c_SPC_SAT) ? r_spc_cnt + c_SPC_W'(1) : r_spc_cnt;

    // The tap is the pop cycle; a token inserted at t is visible at t+WL-1.
    assign w_tap       = r_pipe[c_PIPE_W-1];
    assign w_pipe_next = (r_pipe << 1) | c_PIPE_W'(w_accept);
    assign fifo_ren    = w_tap && !fifo_empty;
    assign w_load_data = fifo_empty ? '0 : fifo_data;

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_shift_next = r_shift;
        w_dq_next    = '0;
        w_oe_next    = 1'b0;
        if (w_tap) begin
            // A load on the last beat restarts the burst with no bus gap.
            w_state_next = S_BURST;
            w_beat_next  = '0;
            w_dq_next    = w_load_data[DQ_WIDTH-1:0];
            w_shift_next = w_load_data >> DQ_WIDTH;
            w_oe_next    = 1'b1;
        end else if (r_state == S_BURST) begin
            if (r_beat == c_LAST_BEAT) begin
                w_state_next = S_IDLE;
                w_beat_next  = '0;
                w_shift_next = '0;
            end else begin
                w_beat_next  = r_beat + c_BEAT_W'(1);
                w_dq_next    = r_shift[DQ_WIDTH-1:0];
                w_shift_next = r_shift >> DQ_WIDTH;
                w_oe_next    = 1'b1;
            end
        end
        w_busy_next = (|w_pipe_next) || (w_state_next == S_BURST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_spc_cnt     <= c_SPC_SAT;
            r_pipe        <= '0;
            r_beat        <= '0;
            r_shift       <= '0;
            dq_out        <= '0;
            dq_oe         <= 1'b0;
            busy          <= 1'b0;
            underflow_err <= 1'b0;
            spacing_err   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_spc_cnt     <= w_spc_next;
            r_pipe        <= w_pipe_next;
            r_beat        <= w_beat_next;
            r_shift       <= w_shift_next;
            dq_out        <= w_dq_next;
            dq_oe         <= w_oe_next;
            busy          <= w_busy_next;
            underflow_err <= underflow_err | (w_tap & fifo_empty);
            spacing_err   <= spacing_err | w_drop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wdata_burst_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdata_burst_issuer
// Purpose  : Directed self-checking bench for wdata_burst_issuer (WL=5 and WL=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdata_burst_issuer;

    localparam int c_DW = 128;
    localparam int c_BL = 8;
    localparam int c_QW = c_DW / c_BL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_cmd_valid = 1'b0;
    logic            wr_cmd2 = 1'b0;
    logic            fifo_empty = 1'b0;
    logic [c_DW-1:0] fifo_data;
    logic            fifo_ren, dq_oe, busy, underflow_err, spacing_err;
    logic [c_QW-1:0] dq_out;
    logic            ren2, oe2, busy2, uf2, sp2;
    logic [c_QW-1:0] dq2;

    int n_tests = 0;
    int n_fail  = 0;
    int pop_idx = 0;

    logic            s_ren, s_oe, s_busy, s_uf, s_sp;
    logic            s2_ren, s2_oe, s2_busy, s2_uf, s2_sp;
    logic [c_QW-1:0] s_dq, s2_dq;

    always #5 clk = ~clk;

    // Entry i, beat k carries 16'h(i)(k); entry 0 is 0x0007_..._0001_0000.
    function automatic logic [c_DW-1:0] make_entry(input int i);
        logic [c_DW-1:0] e;
        for (int k = 0; k < c_BL; k++) e[k*c_QW +: c_QW] = c_QW'(i * 256 + k);
        return e;
    endfunction

    assign fifo_data = make_entry(pop_idx);

    wdata_burst_issuer #(.DATA_WIDTH(c_DW), .BURST_LEN(c_BL), .WL(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_cmd_valid(wr_cmd_valid),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .dq_out(dq_out), .dq_oe(dq_oe), .busy(busy),
        .underflow_err(underflow_err), .spacing_err(spacing_err)
    );

    wdata_burst_issuer #(.DATA_WIDTH(c_DW), .BURST_LEN(c_BL), .WL(2)) u_dut_wl2 (
        .clk(clk), .rst_n(rst_n), .wr_cmd_valid(wr_cmd2),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_ren(ren2),
        .dq_out(dq2), .dq_oe(oe2), .busy(busy2),
        .underflow_err(uf2), .spacing_err(sp2)
    );

    typedef struct {
        string name;
        int    c1, c2;
        bit    empty;
        int    pop_a, pop_b;
        int    oe1_lo, oe1_hi, oe2_lo, oe2_hi;
        int    sp_from, uf_from;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string what, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", what, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        wr_cmd_valid = 1'b0;
        wr_cmd2      = 1'b0;
        fifo_empty   = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pop_idx = 0;
        rst_n   = 1'b1;
    endtask

    // Drives one cycle's inputs, samples both DUTs mid-cycle, advances to next cycle.
    task automatic run_cycle(input bit cmd, input bit cmd2, input bit empty);
        wr_cmd_valid = cmd;
        wr_cmd2      = cmd2;
        fifo_empty   = empty;
        @(negedge clk);
        s_ren  = fifo_ren; s_oe  = dq_oe; s_dq  = dq_out; s_busy  = busy;
        s_uf   = underflow_err; s_sp = spacing_err;
        s2_ren = ren2; s2_oe = oe2; s2_dq = dq2; s2_busy = busy2; s2_uf = uf2; s2_sp = sp2;
        @(posedge clk);
        #1;
        if (s_ren || s2_ren) pop_idx++;
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (lo >= 0) && (c >= lo) && (c <= hi);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int last_hi;
        bit e_oe;
        logic [c_QW-1:0] e_dq;

        vecs[0] = '{"single",    10, -1, 1'b0, 14, -1, 15, 22, -1, -1, -1, -1};
        vecs[1] = '{"b2b",       10, 18, 1'b0, 14, 22, 15, 22, 23, 30, -1, -1};
        vecs[2] = '{"spacing5",  10, 15, 1'b0, 14, -1, 15, 22, -1, -1, 16, -1};
        vecs[3] = '{"spacing7",  10, 17, 1'b0, 14, -1, 15, 22, -1, -1, 18, -1};
        vecs[4] = '{"gap9",      10, 19, 1'b0, 14, 23, 15, 22, 24, 31, -1, -1};
        vecs[5] = '{"underflow", 10, -1, 1'b1, -1, -1, 15, 22, -1, -1, -1, 15};

        foreach (vecs[i]) begin
            do_reset();
            last_hi = (vecs[i].oe2_hi >= 0) ? vecs[i].oe2_hi : vecs[i].oe1_hi;
            for (int c = 0; c < 40; c++) begin
                run_cycle((c == vecs[i].c1) || (c == vecs[i].c2), 1'b0, vecs[i].empty);
                e_oe = in_rng(c, vecs[i].oe1_lo, vecs[i].oe1_hi) ||
                       in_rng(c, vecs[i].oe2_lo, vecs[i].oe2_hi);
                e_dq = '0;
                if (!vecs[i].empty) begin
                    if (in_rng(c, vecs[i].oe1_lo, vecs[i].oe1_hi))
                        e_dq = c_QW'(c - vecs[i].oe1_lo);
                    else if (in_rng(c, vecs[i].oe2_lo, vecs[i].oe2_hi))
                        e_dq = c_QW'(256 + c - vecs[i].oe2_lo);
                end
                check({vecs[i].name, ".ren"}, c, 32'(s_ren),
                      32'((c == vecs[i].pop_a) || (c == vecs[i].pop_b)));
                check({vecs[i].name, ".oe"}, c, 32'(s_oe), 32'(e_oe));
                check({vecs[i].name, ".dq"}, c, 32'(s_dq), 32'(e_dq));
                check({vecs[i].name, ".busy"}, c, 32'(s_busy),
                      32'((c > vecs[i].c1) && (c <= last_hi)));
                check({vecs[i].name, ".uf"}, c, 32'(s_uf),
                      32'((vecs[i].uf_from >= 0) && (c >= vecs[i].uf_from)));
                check({vecs[i].name, ".sp"}, c, 32'(s_sp),
                      32'((vecs[i].sp_from >= 0) && (c >= vecs[i].sp_from)));
            end
        end

        // Asynchronous reset in the middle of a burst, then a fresh command.
        do_reset();
        for (int c = 0; c < 17; c++) run_cycle(c == 10, 1'b0, 1'b0);
        check("rst.pre_ren", 14, 32'(pop_idx), 32'd1);
        #1;
        check("rst.pre_oe", 17, 32'(dq_oe), 32'd1);
        check("rst.pre_dq", 17, 32'(dq_out), 32'h0002);
        rst_n = 1'b0;
        #1;
        check("rst.oe", 17, 32'(dq_oe), 32'd0);
        check("rst.busy", 17, 32'(busy), 32'd0);
        check("rst.ren", 17, 32'(fifo_ren), 32'd0);
        check("rst.dq", 17, 32'(dq_out), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 20; c < 46; c++) begin
            run_cycle(c == 30, 1'b0, 1'b0);
            check("rst2.ren", c, 32'(s_ren), 32'(c == 34));
            check("rst2.oe", c, 32'(s_oe), 32'((c >= 35) && (c <= 42)));
            check("rst2.dq", c, 32'(s_dq),
                  ((c >= 35) && (c <= 42)) ? 32'(256 + c - 35) : 32'd0);
            check("rst2.busy", c, 32'(s_busy), 32'((c >= 31) && (c <= 42)));
        end
        check("rst2.uf", 45, 32'(s_uf), 32'd0);
        check("rst2.sp", 45, 32'(s_sp), 32'd0);

        // Minimum write latency: pop one cycle after the command.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            run_cycle(1'b0, c == 0, 1'b0);
            check("wl2.ren", c, 32'(s2_ren), 32'(c == 1));
            check("wl2.oe", c, 32'(s2_oe), 32'((c >= 2) && (c <= 9)));
            check("wl2.dq", c, 32'(s2_dq), ((c >= 2) && (c <= 9)) ? 32'(c - 2) : 32'd0);
            check("wl2.busy", c, 32'(s2_busy), 32'((c >= 1) && (c <= 9)));
        end
        check("wl2.uf", 13, 32'(s2_uf), 32'd0);
        check("wl2.sp", 13, 32'(s2_sp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
